// File: rtl/spi_transaction_sequencer.sv
// spi_transaction_sequencer
//
// Drives the byte-level handshake of the SPI core. It writes up to MAX_BYTES
// command bytes back-to-back, then collects up to MAX_BYTES response bytes.
// Each response byte follows the same handshake: wait for ready_to_read,
// pulse read_from_spi, then capture data_from_spi.
//
// Ports
//   clk, reset            single clock; asynchronous active-low reset
//   start                 one-cycle request, only honoured while idle
//   tx_count, rx_count    bytes to write / read (saturated to MAX_BYTES)
//   tx_data               command bytes, byte 0 at [7:0] is sent first
//   cfg_spibr, cfg_spicr  core configuration, captured with start
//   busy, done, timeout   status (done/timeout are one-cycle pulses)
//   rx_data               received bytes, byte k at [8k+7:8k]
//   spibr, spicr          configuration to the core
//   data_to_spi, write_to_spi, read_from_spi   strobes to the core
//   data_from_spi, ready_to_read               from the core
module spi_transaction_sequencer #(
    parameter int MAX_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             tx_count,
    input  logic [2:0]             rx_count,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    input  logic [1:0]             cfg_spibr,
    input  logic [2:0]             cfg_spicr,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [8*MAX_BYTES-1:0] rx_data,
    output logic [1:0]             spibr,
    output logic [2:0]             spicr,
    output logic [7:0]             data_to_spi,
    output logic                   write_to_spi,
    output logic                   read_from_spi,
    input  logic [7:0]             data_from_spi,
    input  logic                   ready_to_read
);
    localparam int IW = $clog2(MAX_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_WAIT_RD, S_READ, S_CAPTURE, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [MAX_BYTES-1:0][7:0] tx_q, tx_d;
    logic [MAX_BYTES-1:0][7:0] rx_q, rx_d;
    logic [IW-1:0]             tx_n_q, tx_n_d;
    logic [IW-1:0]             rx_n_q, rx_n_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [TW-1:0]             wait_q, wait_d;
    logic [1:0]                spibr_q, spibr_d;
    logic [2:0]                spicr_q, spicr_d;
    logic [7:0]                data_q, data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      timeout_q, timeout_d;
    logic                      write_q, write_d;
    logic                      read_q, read_d;

    logic [7:0]                tx_sel;
    logic [IW-1:0]             idx_inc;

    function automatic logic [IW-1:0] sat_count(input logic [2:0] c);
        if (32'(c) > 32'(MAX_BYTES)) return IW'(MAX_BYTES);
        return IW'(c);
    endfunction

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        tx_n_d    = tx_n_q;
        rx_n_d    = rx_n_q;
        idx_d     = idx_q;
        wait_d    = '0;
        spibr_d   = spibr_q;
        spicr_d   = spicr_q;
        data_d    = data_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        write_d   = 1'b0;
        read_d    = 1'b0;

        idx_inc = idx_q + IW'(1);
        tx_sel  = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx_q == IW'(k)) tx_sel = tx_q[k];
        end

        // Outputs are registered, so every strobe is decided one cycle ahead:
        // the value computed here is what the core sees in the next state.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Capture everything with the request so the caller only
                    // has to hold its inputs for the start cycle.
                    state_d = S_LOAD;
                    tx_d    = tx_data;
                    tx_n_d  = sat_count(tx_count);
                    rx_n_d  = sat_count(rx_count);
                    spibr_d = cfg_spibr;
                    spicr_d = cfg_spicr;
                end
            end
            S_LOAD: begin
                rx_d  = '0;
                idx_d = '0;
                if (tx_n_q != '0) begin
                    state_d = S_WRITE;
                    write_d = 1'b1;
                    data_d  = tx_q[0];
                    idx_d   = IW'(1);
                end else if (rx_n_q != '0) begin
                    state_d = S_WAIT_RD;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_WRITE: begin
                // idx counts bytes already put on the bus, including this cycle's.
                if (idx_q < tx_n_q) begin
                    write_d = 1'b1;
                    data_d  = tx_sel;
                    idx_d   = idx_inc;
                end else begin
                    idx_d = '0;
                    if (rx_n_q != '0) begin
                        state_d = S_WAIT_RD;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_WAIT_RD: begin
                if (ready_to_read) begin
                    state_d = S_READ;
                    read_d  = 1'b1;
                end else if (wait_q == TW'(TIMEOUT_CYCLES - 2)) begin
                    // Registered pulse lands in the TIMEOUT_CYCLES-th waiting cycle.
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                for (int k = 0; k < MAX_BYTES; k++) begin
                    if (idx_q == IW'(k)) rx_d[k] = data_from_spi;
                end
                idx_d = idx_inc;
                if (idx_inc < rx_n_q) begin
                    state_d = S_WAIT_RD;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            tx_n_q    <= '0;
            rx_n_q    <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            spibr_q   <= '0;
            spicr_q   <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            tx_n_q    <= tx_n_d;
            rx_n_q    <= rx_n_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            spibr_q   <= spibr_d;
            spicr_q   <= spicr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            write_q   <= write_d;
            read_q    <= read_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign rx_data       = rx_q;
    assign spibr         = spibr_q;
    assign spicr         = spicr_q;
    assign data_to_spi   = data_q;
    assign write_to_spi  = write_q;
    assign read_from_spi = read_q;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Scoreboard bench for spi_transaction_sequencer. Stimulus pushes expected
// write bytes, done records and timeout records into queues; a monitor pops
// and compares whenever the DUT strobes write_to_spi, done or timeout.
// A small core model answers read_from_spi from a queue of response bytes.
module tb_spi_transaction_sequencer;
    localparam int MB = 4;
    localparam int TO = 16;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic          start         = 1'b0;
    logic [2:0]    tx_count      = '0;
    logic [2:0]    rx_count      = '0;
    logic [8*MB-1:0] tx_data     = '0;
    logic [1:0]    cfg_spibr     = '0;
    logic [2:0]    cfg_spicr     = '0;
    logic [7:0]    data_from_spi = '0;
    logic          ready_to_read = 1'b0;
    logic          busy, done, timeout;
    logic [8*MB-1:0] rx_data;
    logic [1:0]    spibr;
    logic [2:0]    spicr;
    logic [7:0]    data_to_spi;
    logic          write_to_spi, read_from_spi;

    spi_transaction_sequencer #(.MAX_BYTES(MB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .tx_count(tx_count), .rx_count(rx_count), .tx_data(tx_data),
        .cfg_spibr(cfg_spibr), .cfg_spicr(cfg_spicr),
        .busy(busy), .done(done), .timeout(timeout), .rx_data(rx_data),
        .spibr(spibr), .spicr(spicr), .data_to_spi(data_to_spi),
        .write_to_spi(write_to_spi), .read_from_spi(read_from_spi),
        .data_from_spi(data_from_spi), .ready_to_read(ready_to_read)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rx;
        int          nw;
        int          nr;
        int          at;
        logic [1:0]  br;
        logic [2:0]  cr;
    } done_exp_t;

    done_exp_t   done_exp[$];
    logic [7:0]  wr_exp[$];
    logic [31:0] to_exp[$];
    logic [7:0]  resp_q[$];

    int n_tests = 0, n_fail = 0;
    int nw = 0, nr = 0, last_rd = 0;
    int gap = 0, gap_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: every DUT strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            nw = 0;
            nr = 0;
        end else begin
            if (write_to_spi) begin
                nw++;
                if (wr_exp.size() == 0) fail_now($sformatf("unexpected write %0h", data_to_spi));
                else chk("write byte", data_to_spi, wr_exp.pop_front());
            end
            if (read_from_spi) begin
                nr++;
                last_rd = cyc;
            end
            if (done) begin
                if (done_exp.size() == 0) fail_now("unexpected done");
                else begin
                    done_exp_t e;
                    e = done_exp.pop_front();
                    chk("done rx_data", rx_data, e.rx);
                    chk("done write count", nw, e.nw);
                    chk("done read count", nr, e.nr);
                    chk("done cycle", cyc, e.at);
                    chk("done spibr", spibr, e.br);
                    chk("done spicr", spicr, e.cr);
                end
                nw = 0;
                nr = 0;
            end
            if (timeout) begin
                if (to_exp.size() == 0) fail_now("unexpected timeout");
                else begin
                    chk("timeout rx_data", rx_data, to_exp.pop_front());
                    chk("timeout latency after last read", cyc - last_rd, TO + 1);
                end
                nw = 0;
                nr = 0;
            end
        end
    end

    // Core model: offers a byte while it has one, answers each read pulse,
    // and optionally holds ready low for 'gap' cycles after a read.
    always @(negedge clk) begin
        if (!reset) begin
            resp_q.delete();
            ready_to_read = 1'b0;
            gap_cnt = 0;
        end else if (read_from_spi) begin
            if (resp_q.size() > 0) data_from_spi = resp_q.pop_front();
            ready_to_read = 1'b0;
            gap_cnt = gap;
        end else if (gap_cnt > 0) begin
            gap_cnt--;
            ready_to_read = 1'b0;
        end else begin
            ready_to_read = (resp_q.size() > 0);
        end
    end

    task automatic kick(input logic [2:0] txc, input logic [2:0] rxc, input logic [31:0] txd,
                        input logic [1:0] br, input logic [2:0] cr, output int s);
        @(negedge clk);
        tx_count  = txc;
        rx_count  = rxc;
        tx_data   = txd;
        cfg_spibr = br;
        cfg_spicr = cr;
        start     = 1'b1;
        s         = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic expect_done(input logic [31:0] rx, input int nwr, input int nrd, input int at,
                               input logic [1:0] br, input logic [2:0] cr);
        done_exp_t e;
        e.rx = rx; e.nw = nwr; e.nr = nrd; e.at = at; e.br = br; e.cr = cr;
        done_exp.push_back(e);
    endtask

    task automatic push_writes(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) wr_exp.push_back(8'(d >> (8 * i)));
    endtask

    task automatic push_resp(input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) resp_q.push_back(8'(d >> (8 * i)));
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 500);
        if (busy) fail_now({nm, ": busy never fell"});
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s;
        int k;

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done/timeout", {done, timeout}, 0);
        chk("reset strobes", {write_to_spi, read_from_spi}, 0);
        chk("reset data_to_spi", data_to_spi, 0);
        chk("reset cfg", {spibr, spicr}, 0);
        chk("reset rx_data", rx_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Flash ID: 4 writes, 4 reads
        push_writes(32'h73F2769F, 4);
        push_resp(32'h001840EF, 4);
        kick(3'd4, 3'd4, 32'h73F2769F, 2'b01, 3'b011, s);
        chk("busy in LOAD", busy, 1);
        expect_done(32'h001840EF, 4, 4, s + 18, 2'b01, 3'b011);
        wait_idle("flash id");

        // Write-only
        push_writes(32'h0000A55A, 2);
        kick(3'd2, 3'd0, 32'h0000A55A, 2'b11, 3'b100, s);
        expect_done(32'h0, 2, 0, s + 4, 2'b11, 3'b100);
        wait_idle("write only");

        // Zero counts
        kick(3'd0, 3'd0, 32'h12345678, 2'b00, 3'b001, s);
        expect_done(32'h0, 0, 0, s + 2, 2'b00, 3'b001);
        wait_idle("zero counts");

        // Timeout: 3 bytes requested, only one arrives
        push_resp(32'h0000005A, 1);
        to_exp.push_back(32'h0000005A);
        kick(3'd0, 3'd3, 32'h0, 2'b01, 3'b010, s);
        wait_idle("timeout");
        chk("rx_data held after timeout", rx_data, 32'h0000005A);

        // Start while busy: pulses in WRITE and in DONE must be ignored
        push_writes(32'h00CCBBAA, 3);
        kick(3'd3, 3'd0, 32'h00CCBBAA, 2'b10, 3'b110, s);
        expect_done(32'h0, 3, 0, s + 5, 2'b10, 3'b110);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!done) fail_now("start-while-busy: done never seen");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("start while busy");
        chk("idle after start in DONE", busy, 0);

        // Saturation plus cfg changing mid-transaction
        push_writes(32'h44332211, 4);
        push_resp(32'hD4C3B2A1, 4);
        kick(3'd6, 3'd7, 32'h44332211, 2'b10, 3'b101, s);
        cfg_spibr = 2'b01;
        cfg_spicr = 3'b010;
        expect_done(32'hD4C3B2A1, 4, 4, s + 18, 2'b10, 3'b101);
        wait_idle("saturation");

        // Reset while waiting for byte 2
        gap = 5;
        push_writes(32'h000000C3, 1);
        push_resp(32'h00332211, 3);
        kick(3'd1, 3'd3, 32'h000000C3, 2'b11, 3'b111, s);
        k = 0;
        while (!read_from_spi && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!read_from_spi) fail_now("reset test: first read never seen");
        repeat (2) @(negedge clk);
        chk("rx byte 0 before reset", rx_data, 32'h00000011);
        reset = 1'b0;
        #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset pulses", {done, timeout, write_to_spi, read_from_spi}, 0);
        chk("mid reset data/cfg", {data_to_spi, spibr, spicr}, 0);
        chk("mid reset rx_data", rx_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        gap = 0;

        // Normal transaction after reset
        push_writes(32'h0000BEEF, 2);
        push_resp(32'h00000201, 2);
        kick(3'd2, 3'd2, 32'h0000BEEF, 2'b10, 3'b001, s);
        expect_done(32'h00000201, 2, 2, s + 10, 2'b10, 3'b001);
        wait_idle("after reset");

        chk("pending writes", wr_exp.size(), 0);
        chk("pending dones", done_exp.size(), 0);
        chk("pending timeouts", to_exp.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
